vip_bit_morphology: RTL and testbench
=====================================

# vip_bit_morphology

Binary 3x3 morphological filter (erosion or dilation) for the 1-bit edge stream produced by the Sobel edge-detection stage. It consumes the Sobel output (vsync / href / clken / bit) and emits a cleaned 1-bit stream with identical framing. The output feeds the capture/output path, where it is expanded to 8-bit R/G/B.

## Interface
- IMG_HDISP, 400, active pixels per line
- IMG_VDISP, 400, active lines per frame
- MODE, 0, 0 = erode (3x3 AND), 1 = dilate (3x3 OR)
- clk  in  1  pixel clock, single clock domain
- rst  in  1  reset; synchronous and active-high
- pre_frame_vsync  in  1  frame valid; high during frame, low during frame sync
- pre_frame_href  in  1  line valid
- pre_frame_clken  in  1  pixel strobe; a pixel is accepted when href & clken
- pre_img_bit  in  1  input binary pixel
- post_frame_vsync  out  1  pre_frame_vsync delayed 2 clk
- post_frame_href  out  1  pre_frame_href delayed 2 clk
- post_frame_clken  out  1  accepted-pixel strobe delayed 2 clk; gated by sync state
- post_img_bit  out  1  filtered pixel

## Operation
- **Pixel accept.** A pixel is accepted only when sync state is SYNCED, href = 1 and clken = 1. Otherwise the window, counters and line buffers hold.
- **Sync FSM:**
  - States: WAIT_FRAME (reset state) and SYNCED.
  - WAIT_FRAME -> SYNCED on a rising edge of pre_frame_vsync (registered copy 0, current 1).
  - SYNCED never leaves except via rst.
  - In WAIT_FRAME, post_frame_clken = 0 and post_img_bit = 0; vsync and href still propagate delayed.
- **Column counter col:**
  - Clears when href = 0.
  - Increments per accepted pixel and saturates at IMG_HDISP.
- **Row counter row:**
  - Clears while vsync = 0.
  - Increments on each href falling edge, saturating at 2. Only row ≥ 1 and row ≥ 2 matter.
- **Line buffers:**
  - Two 1-bit x IMG_HDISP memories, lb0 (previous line) and lb1 (line before that), addressed by col.
  - On each accepted pixel with col < IMG_HDISP: lb1[col] <= lb0[col], lb0[col] <= pre_img_bit.
  - Buffer contents are never cleared; validity comes only from the row/col masks.
- **Window:**
  - 3x3 register window. On each accept, it shifts left and loads column {lb1[col], lb0[col], pre_img_bit}.
  - Output for input position (x, y) reduces input taps (x-2..x, y-2..y).
  - Result: the output image is shifted one pixel right and one down relative to a centered kernel. This is a decided property; pixel count is preserved.
- **Padding:**
  - A tap is invalid if its row < 0 (row < 2 or < 1 masks) or its column < 0 (col < 2 or < 1 masks).
  - Invalid taps read as the padding value: 1 in erode, 0 in dilate (neutral element).
- **Overlong lines.** Pixels accepted with col ≥ IMG_HDISP are not written to the line buffers. Their output is 0.
- **Short frames/lines** need no special handling; counters restart on the next href/vsync.

## Timing
- **Latency.** Fixed 2 clk from an accepted input to its post_frame_clken pulse.
  - Stage 1: line-buffer read and window shift.
  - Stage 2: AND/OR reduction registered into post_img_bit.
- **Strobe gaps.** A clken gap on input gives an identical gap on output. There is no buffering and no backpressure.
- **Simultaneous events.** If href falls in the same cycle as the last accepted pixel, that pixel is processed before row increments.
- **Reset values.** All outputs are 0. FSM is WAIT_FRAME. col = 0, row = 0. Window and delay pipes are 0.
- **Reset mid-frame.**
  - Outputs go to 0 on the next edge.
  - The block stays in WAIT_FRAME until the next vsync rising edge.
  - The remainder of the interrupted frame produces no post_frame_clken pulses.

## Structure
- Shared VIP package (constants only): MODE_ERODE = 0, MODE_DILATE = 1, and the pipeline-latency constant (2) that downstream capture logic uses.
- One sub-module, vip_bit_line_buffer:
  - Parameterized depth.
  - Synchronous 1-bit dual-line shift memory.
  - Write-enable and address in; two tap outputs.
- Window, masks, reduction and FSM live in the top module.

## Test plan
Benches use IMG_HDISP = 8, IMG_VDISP = 6, continuous clken unless stated.

1. **Erode, all-ones frame** -> all 48 output pixels = 1. post_frame_clken pulses exactly 48 times, each 2 clk after its input.
2. **Erode, all ones except input (4,3) = 0** -> output 0 exactly at (4..6, 3..5) ∩ image (9 pixels). All others = 1.
3. **Dilate, all zeros except input (3,2) = 1** -> output 1 exactly at (3..5, 2..4). All others = 0.
4. **Dilate, same image, clken low every other cycle within href** -> identical pixel values. Output strobe pattern equals input pattern delayed 2 clk.
5. **rst pulsed during line 3 of frame 1, then a full frame 2 as in test 3** -> no post_frame_clken for the rest of frame 1. Frame 2 output exactly as in test 3.
6. **Line of 10 accepted pixels (overlong)** -> pixels 8 and 9 output 0. The next line's window taps are unaffected: repeat test 3 after it and get identical results.

Source files
------------

// File: rtl/vip_bit_morphology_pkg.sv
// Shared constants for the binary morphology stage and the capture logic that
// consumes its output.
package vip_bit_morphology_pkg;

  localparam int MODE_ERODE   = 0;
  localparam int MODE_DILATE  = 1;
  localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/vip_bit_line_buffer.sv
// Two-line 1-bit shift memory: a write moves the previous-line bit into the
// older line and stores the new pixel, both at the same column address.
module vip_bit_line_buffer #(
  parameter  int DEPTH = 400,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          din_i,
  output logic          tap0_o,
  output logic          tap1_o
);

  logic line0Mem_q [DEPTH];
  logic line1Mem_q [DEPTH];
  logic inRange;

  assign inRange = (int'(addr_i) < DEPTH);

  always_ff @(posedge clk) begin
    if (we_i && inRange) begin
      line1Mem_q[addr_i] <= line0Mem_q[addr_i];
      line0Mem_q[addr_i] <= din_i;
    end
  end

  // Non-power-of-two depths leave unused addresses; they read as 0.
  always_comb begin
    tap0_o = 1'b0;
    tap1_o = 1'b0;
    if (inRange) begin
      tap0_o = line0Mem_q[addr_i];
      tap1_o = line1Mem_q[addr_i];
    end
  end

endmodule

// File: rtl/vip_bit_morphology.sv
// Binary 3x3 erosion/dilation on the Sobel edge stream; output keeps the input
// framing, delayed by PIPE_LATENCY clocks, with the kernel anchored bottom-right.
module vip_bit_morphology
  import vip_bit_morphology_pkg::*;
#(
  parameter int IMG_HDISP = 400,
  parameter int IMG_VDISP = 400,
  parameter int MODE      = MODE_ERODE
) (
  input  logic clk,
  input  logic rst,
  input  logic pre_frame_vsync,
  input  logic pre_frame_href,
  input  logic pre_frame_clken,
  input  logic pre_img_bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_bit
);

  localparam int         CW      = $clog2(IMG_HDISP + 1);
  localparam int         LB_AW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [1:0] ROW_MAX = (IMG_VDISP < 2) ? 2'(IMG_VDISP) : 2'd2;
  localparam logic       PAD     = (MODE == MODE_DILATE) ? 1'b0 : 1'b1;

  typedef enum logic {
    WAIT_FRAME,
    SYNCED
  } syncState_e;

  syncState_e              state_q;
  logic                    vsyncPrev_q;
  logic                    hrefPrev_q;
  logic [CW-1:0]           col_q;
  logic [CW-1:0]           col_d;
  logic [1:0]              row_q;
  logic [1:0]              row_d;
  logic                    accept;
  logic                    colFull;
  logic                    hrefFall;
  logic                    lbWrite;
  logic                    lb0Tap;
  logic                    lb1Tap;
  logic [2:0]              winR0_q;
  logic [2:0]              winR1_q;
  logic [2:0]              winR2_q;
  logic                    colGe1_q;
  logic                    colGe2_q;
  logic                    rowGe1_q;
  logic                    rowGe2_q;
  logic                    over_q;
  logic                    s1Valid_q;
  logic [PIPE_LATENCY-1:0] vsyncPipe_q;
  logic [PIPE_LATENCY-1:0] hrefPipe_q;
  logic                    postClken_q;
  logic                    postBit_q;
  logic [2:0]              colOk;
  logic [2:0]              tapsR0;
  logic [2:0]              tapsR1;
  logic [2:0]              tapsR2;
  logic                    filtBit;

  assign accept   = (state_q == SYNCED) && pre_frame_href && pre_frame_clken;
  assign colFull  = (col_q >= CW'(IMG_HDISP));
  assign hrefFall = hrefPrev_q && !pre_frame_href;
  assign lbWrite  = accept && !colFull;

  // The previous-edge register resets high so that a reset taken in the middle
  // of a frame waits for a genuine low-to-high vsync transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FRAME;
      vsyncPrev_q <= 1'b1;
    end else begin
      vsyncPrev_q <= pre_frame_vsync;
      if (state_q == WAIT_FRAME && !vsyncPrev_q && pre_frame_vsync) begin
        state_q <= SYNCED;
      end
    end
  end

  always_comb begin
    col_d = col_q;
    if (!pre_frame_href) begin
      col_d = '0;
    end else if (accept && !colFull) begin
      col_d = col_q + 1'b1;
    end
    row_d = row_q;
    if (!pre_frame_vsync) begin
      row_d = '0;
    end else if (hrefFall && (row_q < ROW_MAX)) begin
      row_d = row_q + 1'b1;
    end
  end

  vip_bit_line_buffer #(
    .DEPTH (IMG_HDISP)
  ) uLineBuffer (
    .clk    (clk),
    .we_i   (lbWrite),
    .addr_i (col_q[LB_AW-1:0]),
    .din_i  (pre_img_bit),
    .tap0_o (lb0Tap),
    .tap1_o (lb1Tap)
  );

  // Bit 2 of each window row is the newest column (x), bit 0 the oldest (x-2).
  function automatic logic [2:0] padTaps(input logic [2:0] taps, input logic [2:0] ok);
    return (taps & ok) | (~ok & {3{PAD}});
  endfunction

  always_comb begin
    colOk   = {1'b1, colGe1_q, colGe2_q};
    tapsR2  = padTaps(winR2_q, colOk);
    tapsR1  = padTaps(winR1_q, colOk & {3{rowGe1_q}});
    tapsR0  = padTaps(winR0_q, colOk & {3{rowGe2_q}});
    filtBit = 1'b0;
    if (MODE == MODE_DILATE) begin
      filtBit = |{tapsR0, tapsR1, tapsR2};
    end else begin
      filtBit = &{tapsR0, tapsR1, tapsR2};
    end
    filtBit = filtBit && !over_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hrefPrev_q  <= 1'b0;
      winR0_q     <= '0;
      winR1_q     <= '0;
      winR2_q     <= '0;
      colGe1_q    <= 1'b0;
      colGe2_q    <= 1'b0;
      rowGe1_q    <= 1'b0;
      rowGe2_q    <= 1'b0;
      over_q      <= 1'b0;
      s1Valid_q   <= 1'b0;
      vsyncPipe_q <= '0;
      hrefPipe_q  <= '0;
      postClken_q <= 1'b0;
      postBit_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hrefPrev_q  <= pre_frame_href;
      vsyncPipe_q <= {vsyncPipe_q[PIPE_LATENCY-2:0], pre_frame_vsync};
      hrefPipe_q  <= {hrefPipe_q[PIPE_LATENCY-2:0], pre_frame_href};
      s1Valid_q   <= accept;
      if (accept) begin
        winR0_q  <= {lb1Tap, winR0_q[2:1]};
        winR1_q  <= {lb0Tap, winR1_q[2:1]};
        winR2_q  <= {pre_img_bit, winR2_q[2:1]};
        colGe1_q <= (col_q >= CW'(1));
        colGe2_q <= (col_q >= CW'(2));
        rowGe1_q <= (row_q >= 2'd1);
        rowGe2_q <= (row_q >= 2'd2);
        over_q   <= colFull;
      end
      postClken_q <= s1Valid_q;
      postBit_q   <= s1Valid_q && filtBit;
    end
  end

  assign post_frame_vsync = vsyncPipe_q[PIPE_LATENCY-1];
  assign post_frame_href  = hrefPipe_q[PIPE_LATENCY-1];
  assign post_frame_clken = postClken_q;
  assign post_img_bit     = postBit_q;

endmodule

// File: tb/tb_vip_bit_morphology.sv
// Scoreboard bench for vip_bit_morphology: an erode and a dilate instance share
// one stimulus stream and are compared against a reference 3x3 model.
module tb_vip_bit_morphology;

  localparam int H = 8;
  localparam int V = 6;
  localparam int MAXW = 10;

  typedef struct {
    bit val;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  logic vsync;
  logic href;
  logic clken;
  logic pixel;
  logic postVsyncE, postHrefE, postClkenE, postBitE;
  logic postVsyncD, postHrefD, postClkenD, postBitD;

  int   cyc;
  int   checks;
  int   errors;
  int   pulsesE;
  int   pulsesD;
  bit   synced;
  bit   img [V][MAXW];
  int   lineLen [V];
  exp_t qE [$];
  exp_t qD [$];

  vip_bit_morphology #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .MODE      (0)
  ) dutErode (
    .clk              (clk),
    .rst              (rst),
    .pre_frame_vsync  (vsync),
    .pre_frame_href   (href),
    .pre_frame_clken  (clken),
    .pre_img_bit      (pixel),
    .post_frame_vsync (postVsyncE),
    .post_frame_href  (postHrefE),
    .post_frame_clken (postClkenE),
    .post_img_bit     (postBitE)
  );

  vip_bit_morphology #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .MODE      (1)
  ) dutDilate (
    .clk              (clk),
    .rst              (rst),
    .pre_frame_vsync  (vsync),
    .pre_frame_href   (href),
    .pre_frame_clken  (clken),
    .pre_img_bit      (pixel),
    .post_frame_vsync (postVsyncD),
    .post_frame_href  (postHrefD),
    .post_frame_clken (postClkenD),
    .post_img_bit     (postBitD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d cyc=%0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: output at (x,y) reduces taps x-2..x, y-2..y; negative taps pad.
  function automatic bit refPixel(input bit dilate, input int x, input int y);
    bit acc;
    bit tap;
    if (x >= H) return 1'b0;
    acc = !dilate;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        if ((y - dy) < 0 || (x - dx) < 0) tap = !dilate;
        else tap = img[y - dy][x - dx];
        acc = dilate ? (acc | tap) : (acc & tap);
      end
    end
    return acc;
  endfunction

  task automatic pushExpect(input int x, input int y);
    exp_t e;
    e.due = cyc + 2;
    e.val = refPixel(1'b0, x, y);
    qE.push_back(e);
    e.val = refPixel(1'b1, x, y);
    qD.push_back(e);
  endtask

  task automatic setImage(input bit fill, input int sx, input int sy);
    for (int y = 0; y < V; y++) begin
      lineLen[y] = H;
      for (int x = 0; x < MAXW; x++) img[y][x] = fill;
    end
    if (sx >= 0) img[sy][sx] = !fill;
  endtask

  // Drives one frame; optionally pulses rst on line rstLine after pixel rstPix.
  task automatic applyStimulus(input bit gapMode, input int rstLine, input int rstPix);
    vsync = 1'b0; href = 1'b0; clken = 1'b0; pixel = 1'b0;
    repeat (3) step();
    vsync = 1'b1;
    synced = 1'b1;
    step();
    checkOutput("vsyncDelay1E", postVsyncE, 0);
    checkOutput("vsyncDelay1D", postVsyncD, 0);
    step();
    checkOutput("vsyncDelay2E", postVsyncE, 1);
    checkOutput("vsyncDelay2D", postVsyncD, 1);
    step();
    for (int y = 0; y < V; y++) begin
      int x;
      bit phase;
      x = 0;
      phase = 1'b0;
      href = 1'b1;
      while (x < lineLen[y]) begin
        if (gapMode && phase) begin
          clken = 1'b0;
        end else begin
          clken = 1'b1;
          pixel = img[y][x];
          if (synced) pushExpect(x, y);
          x++;
        end
        phase = !phase;
        step();
        if (y == rstLine && x == rstPix && clken) begin
          clken = 1'b0;
          repeat (3) step();
          rst = 1'b1;
          step();
          checkOutput("rstClkenE", postClkenE, 0);
          checkOutput("rstClkenD", postClkenD, 0);
          checkOutput("rstBitE", postBitE, 0);
          checkOutput("rstBitD", postBitD, 0);
          rst = 1'b0;
          synced = 1'b0;
        end
      end
      href = 1'b0;
      clken = 1'b0;
      repeat (3) step();
    end
    vsync = 1'b0;
    step();
  endtask

  task automatic drainAndCheck(input string tag);
    repeat (6) step();
    checkOutput({tag, "_pendingE"}, qE.size(), 0);
    checkOutput({tag, "_pendingD"}, qD.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (postClkenE) begin
      pulsesE++;
      checkOutput("strobeExpectedE", int'(qE.size() > 0), 1);
      if (qE.size() > 0) begin
        e = qE.pop_front();
        checkOutput("pixelE", postBitE, e.val);
        checkOutput("latencyE", cyc, e.due);
      end
    end
    if (postClkenD) begin
      pulsesD++;
      checkOutput("strobeExpectedD", int'(qD.size() > 0), 1);
      if (qD.size() > 0) begin
        e = qD.pop_front();
        checkOutput("pixelD", postBitD, e.val);
        checkOutput("latencyD", cyc, e.due);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; pulsesE = 0; pulsesD = 0; synced = 1'b0;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; pixel = 1'b0;
    repeat (4) step();
    checkOutput("resetVsyncE", postVsyncE, 0);
    checkOutput("resetHrefE", postHrefE, 0);
    checkOutput("resetClkenE", postClkenE, 0);
    checkOutput("resetBitE", postBitE, 0);
    checkOutput("resetVsyncD", postVsyncD, 0);
    checkOutput("resetHrefD", postHrefD, 0);
    checkOutput("resetClkenD", postClkenD, 0);
    checkOutput("resetBitD", postBitD, 0);
    rst = 1'b0;
    step();

    $display("[TB] test 1: all-ones frame");
    setImage(1'b1, -1, 0);
    pulsesE = 0; pulsesD = 0;
    applyStimulus(1'b0, -1, -1);
    drainAndCheck("t1");
    checkOutput("t1_pulseCountE", pulsesE, 48);
    checkOutput("t1_pulseCountD", pulsesD, 48);

    $display("[TB] test 2: all ones, hole at (4,3)");
    setImage(1'b1, 4, 3);
    applyStimulus(1'b0, -1, -1);
    drainAndCheck("t2");

    $display("[TB] test 3: all zeros, dot at (3,2)");
    setImage(1'b0, 3, 2);
    applyStimulus(1'b0, -1, -1);
    drainAndCheck("t3");

    $display("[TB] test 4: same image, clken every other cycle");
    pulsesE = 0; pulsesD = 0;
    applyStimulus(1'b1, -1, -1);
    drainAndCheck("t4");
    checkOutput("t4_pulseCountD", pulsesD, 48);

    $display("[TB] test 5: reset during line 3, then full frame");
    applyStimulus(1'b0, 2, 3);
    drainAndCheck("t5a");
    applyStimulus(1'b0, -1, -1);
    drainAndCheck("t5b");

    $display("[TB] test 6: overlong first line, then dot frame");
    setImage(1'b0, -1, 0);
    lineLen[0] = MAXW;
    for (int x = 0; x < MAXW; x++) img[0][x] = 1'b1;
    pulsesE = 0; pulsesD = 0;
    applyStimulus(1'b0, -1, -1);
    drainAndCheck("t6a");
    checkOutput("t6_pulseCountE", pulsesE, 50);
    setImage(1'b0, 3, 2);
    applyStimulus(1'b0, -1, -1);
    drainAndCheck("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
